// File: rtl/hdmi_pkg.sv
`default_nettype none
// hdmi_pkg: packet-type codes, ASP layout encoding and subpacket payload type for the packet scheduler.
// Revision 1.0
package hdmi_pkg;

  localparam logic [7:0] PKT_NULL = 8'h00;
  localparam logic [7:0] PKT_ACR  = 8'h01;
  localparam logic [7:0] PKT_ASP  = 8'h02;
  localparam logic [7:0] PKT_AVI  = 8'h82;
  localparam logic [7:0] PKT_SPD  = 8'h83;
  localparam logic [7:0] PKT_AIF  = 8'h84;

  localparam int IEC_FRAME_MOD = 192;

  typedef enum logic {
    LAYOUT_2CH = 1'b0,
    LAYOUT_8CH = 1'b1
  } asp_layout_t;

  // Eight 24-bit lanes per subpacket; only lanes 0 and 1 ever carry audio.
  typedef struct packed {
    logic [7:0][23:0] lane;
  } asp_subpacket_t;

  function automatic logic [3:0] present_mask(input logic [2:0] frames);
    case (frames)
      3'd1:    present_mask = 4'b0001;
      3'd2:    present_mask = 4'b0011;
      3'd3:    present_mask = 4'b0111;
      3'd4:    present_mask = 4'b1111;
      default: present_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [2:0] present_count(input logic [3:0] present);
    present_count = 3'(present[0]) + 3'(present[1]) + 3'(present[2]) + 3'(present[3]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// sample_fifo: synchronous FIFO with occupancy output and a four-entry head window popped up to four at a time.
// Revision 1.0
module sample_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic [2:0]              pop_count,
  output logic [3:0][WIDTH-1:0]   head,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr + AW'(pop_count);
      level  <= level + LW'(push) - LW'(pop_count);
    end
  end

  // Storage needs no reset: the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_head
    assign head[k] = mem[rd_ptr + AW'(k)];
  end

endmodule
`default_nettype wire

// File: rtl/packet_scheduler.sv
`default_nettype none
// packet_scheduler: selects the HDMI data-island packet for each slot and packs buffered audio into ASPs.
// Revision 1.0
module packet_scheduler
  import hdmi_pkg::*;
#(
  parameter int AUDIO_BIT_WIDTH  = 16,
  parameter int CHANNELS         = 2,
  parameter int FIFO_DEPTH       = 8,
  parameter int INFOFRAME_PERIOD = 1,
  parameter int MAX_HOLD         = 4
) (
  input  logic                                clk_pixel,
  input  logic                                reset_n,
  input  logic                                video_field_end,
  input  logic                                packet_enable,
  input  logic [4:0]                          packet_pixel_counter,
  input  logic                                acr_req,
  input  logic                                sample_valid,
  output logic                                sample_ready,
  input  logic [CHANNELS*AUDIO_BIT_WIDTH-1:0] sample_word,
  output logic [7:0]                          packet_type,
  output asp_subpacket_t [3:0]                asp_word,
  output logic [3:0]                          asp_present,
  output logic                                asp_layout,
  output logic [7:0]                          frame_counter,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level
);

  localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int STORE_W = CHANNELS * 24;
  localparam asp_layout_t LAYOUT = (CHANNELS == 8) ? LAYOUT_8CH : LAYOUT_2CH;

  if (CHANNELS != 2 && CHANNELS != 8) begin : g_bad_channels
    $error("packet_scheduler: CHANNELS must be 2 or 8");
  end

  logic rst_sync;
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= 1'b0;
    end else begin
      rst_sync <= 1'b1;
    end
  end

  logic [STORE_W-1:0]       store_word;
  logic [3:0][STORE_W-1:0]  fifo_head;
  logic [2:0]               pop_count;
  logic                     push;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_justify
    assign store_word[c*24 +: 24] =
      24'(sample_word[c*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH]) << (24 - AUDIO_BIT_WIDTH);
  end

  assign sample_ready = rst_sync && (fifo_level < LVL_W'(FIFO_DEPTH));
  assign push         = sample_valid && sample_ready;
  assign asp_layout   = LAYOUT;

  sample_fifo #(
    .WIDTH (STORE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_pixel),
    .rst_n     (rst_sync),
    .push      (push),
    .push_data (store_word),
    .pop_count (pop_count),
    .head      (fifo_head),
    .level     (fifo_level)
  );

  logic       acr_pending;
  logic       aif_due;
  logic       avi_due;
  logic       spd_due;
  logic [1:0] field_cnt;
  logic [3:0] hold_count;

  logic field_tick;
  logic acr_eff;
  logic aif_eff;
  logic avi_eff;
  logic spd_eff;
  logic level_nz;
  logic level_ge4;
  logic asp_ok;
  logic [7:0] sel_type;
  logic [2:0] pop_frames;
  logic [3:0] present_sel;
  logic [2:0] carried;
  asp_subpacket_t [3:0] asp_next;

  // A field end arriving with a slot is folded into the due flags before selection.
  assign field_tick = video_field_end && (field_cnt == 2'(INFOFRAME_PERIOD - 1));
  assign acr_eff    = acr_pending || acr_req;
  assign aif_eff    = aif_due || field_tick;
  assign avi_eff    = avi_due || field_tick;
  assign spd_eff    = spd_due || field_tick;
  assign level_nz   = (fifo_level != '0);
  assign level_ge4  = (fifo_level >= LVL_W'(4));

  if (CHANNELS == 8) begin : g_layout8
    logic unused_head;
    assign unused_head = ^{fifo_head[3], fifo_head[2], fifo_head[1]};
    assign asp_ok      = level_nz;
    assign pop_frames  = 3'd1;
    assign present_sel = 4'b1111;
    assign carried     = 3'd1;
    always_comb begin
      asp_next = '0;
      for (int sp = 0; sp < 4; sp++) begin
        asp_next[sp].lane[0] = fifo_head[0][(2*sp)*24 +: 24];
        asp_next[sp].lane[1] = fifo_head[0][(2*sp+1)*24 +: 24];
      end
    end
  end else begin : g_layout2
    assign asp_ok      = level_ge4 || (level_nz && (hold_count >= 4'(MAX_HOLD)));
    assign pop_frames  = level_ge4 ? 3'd4 : fifo_level[2:0];
    assign present_sel = present_mask(pop_frames);
    assign carried     = present_count(asp_present);
    always_comb begin
      asp_next = '0;
      for (int sp = 0; sp < 4; sp++) begin
        if (present_sel[sp]) begin
          asp_next[sp].lane[0] = fifo_head[sp][23:0];
          asp_next[sp].lane[1] = fifo_head[sp][47:24];
        end
      end
    end
  end

  always_comb begin
    sel_type = PKT_NULL;
    if (acr_eff) begin
      sel_type = PKT_ACR;
    end else if (asp_ok) begin
      sel_type = PKT_ASP;
    end else if (aif_eff) begin
      sel_type = PKT_AIF;
    end else if (avi_eff) begin
      sel_type = PKT_AVI;
    end else if (spd_eff) begin
      sel_type = PKT_SPD;
    end
  end

  logic take_acr;
  logic take_asp;
  logic take_aif;
  logic take_avi;
  logic take_spd;

  assign take_acr  = packet_enable && (sel_type == PKT_ACR);
  assign take_asp  = packet_enable && (sel_type == PKT_ASP);
  assign take_aif  = packet_enable && (sel_type == PKT_AIF);
  assign take_avi  = packet_enable && (sel_type == PKT_AVI);
  assign take_spd  = packet_enable && (sel_type == PKT_SPD);
  assign pop_count = take_asp ? pop_frames : 3'd0;

  logic [8:0] fc_sum;
  logic [7:0] fc_next;
  assign fc_sum  = {1'b0, frame_counter} + 9'(carried);
  assign fc_next = (fc_sum >= 9'(IEC_FRAME_MOD)) ? 8'(fc_sum - 9'(IEC_FRAME_MOD)) : fc_sum[7:0];

  always_ff @(posedge clk_pixel or negedge rst_sync) begin
    if (!rst_sync) begin
      packet_type   <= PKT_NULL;
      asp_present   <= 4'b0000;
      asp_word      <= '0;
      frame_counter <= 8'd0;
      hold_count    <= 4'd0;
      acr_pending   <= 1'b0;
      aif_due       <= 1'b1;
      avi_due       <= 1'b1;
      spd_due       <= 1'b1;
      field_cnt     <= 2'd0;
    end else begin
      if (video_field_end) begin
        field_cnt <= field_tick ? 2'd0 : field_cnt + 2'd1;
      end
      // A new request landing on the slot that serves an older one stays pending.
      acr_pending <= take_acr ? (acr_pending && acr_req) : acr_eff;
      aif_due     <= aif_eff && !take_aif;
      avi_due     <= avi_eff && !take_avi;
      spd_due     <= spd_eff && !take_spd;

      if (packet_enable) begin
        packet_type <= sel_type;
        if (take_asp) begin
          asp_present <= present_sel;
          asp_word    <= asp_next;
          hold_count  <= 4'd0;
        end else begin
          asp_present <= 4'b0000;
          asp_word    <= '0;
          if (level_nz && !level_ge4 && (hold_count != 4'hF)) begin
            hold_count <= hold_count + 4'd1;
          end
        end
      end

      if ((packet_pixel_counter == 5'd31) && (packet_type == PKT_ASP)) begin
        frame_counter <= fc_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_packet_scheduler.sv
`default_nettype none
// tb_packet_scheduler: directed self-checking bench for a layout-0 and a layout-1 packet_scheduler.
// Revision 1.0
module tb_packet_scheduler;
  import hdmi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        vfe;
  logic        pe;
  logic [4:0]  ppc;
  logic        acr;

  logic        valid0;
  logic [31:0] word0;
  logic        ready0;
  logic [7:0]  ptype0;
  asp_subpacket_t [3:0] asp0;
  logic [3:0]  present0;
  logic        layout0;
  logic [7:0]  fc0;
  logic [3:0]  level0;

  logic         valid1;
  logic [159:0] word1;
  logic         ready1;
  logic [7:0]   ptype1;
  asp_subpacket_t [3:0] asp1;
  logic [3:0]   present1;
  logic         layout1;
  logic [7:0]   fc1;
  logic [2:0]   level1;

  packet_scheduler #(
    .AUDIO_BIT_WIDTH (16), .CHANNELS (2), .FIFO_DEPTH (8),
    .INFOFRAME_PERIOD (1), .MAX_HOLD (2)
  ) dut0 (
    .clk_pixel (clk), .reset_n (reset_n), .video_field_end (vfe),
    .packet_enable (pe), .packet_pixel_counter (ppc), .acr_req (acr),
    .sample_valid (valid0), .sample_ready (ready0), .sample_word (word0),
    .packet_type (ptype0), .asp_word (asp0), .asp_present (present0),
    .asp_layout (layout0), .frame_counter (fc0), .fifo_level (level0)
  );

  packet_scheduler #(
    .AUDIO_BIT_WIDTH (20), .CHANNELS (8), .FIFO_DEPTH (4),
    .INFOFRAME_PERIOD (1), .MAX_HOLD (4)
  ) dut1 (
    .clk_pixel (clk), .reset_n (reset_n), .video_field_end (vfe),
    .packet_enable (pe), .packet_pixel_counter (ppc), .acr_req (acr),
    .sample_valid (valid1), .sample_ready (ready1), .sample_word (word1),
    .packet_type (ptype1), .asp_word (asp1), .asp_present (present1),
    .asp_layout (layout1), .frame_counter (fc1), .fifo_level (level1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [31:0] w);
    valid0 = 1'b1;
    word0  = w;
    cyc();
    valid0 = 1'b0;
  endtask

  task automatic pe_pulse();
    pe = 1'b1;
    cyc();
    pe = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: observed still running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; vfe = 1'b0; pe = 1'b0; ppc = 5'd0; acr = 1'b0;
    valid0 = 1'b0; word0 = '0; valid1 = 1'b0; word1 = '0;
    repeat (3) cyc();

    chk("rst_ready", 64'(ready0), 64'd0);
    chk("rst_type", 64'(ptype0), 64'h00);
    chk("rst_present", 64'(present0), 64'd0);
    chk("rst_level", 64'(level0), 64'd0);
    chk("rst_fc", 64'(fc0), 64'd0);
    chk("layout0", 64'(layout0), 64'd0);
    chk("layout1", 64'(layout1), 64'd1);

    #2 reset_n = 1'b1;
    cyc();
    chk("ready_after_release", 64'(ready0), 64'd1);

    // InfoFrames are all due out of reset
    pe_pulse(); chk("if_aif", 64'(ptype0), 64'h84); chk("if_aif_l1", 64'(ptype1), 64'h84);
    cyc();      chk("if_hold", 64'(ptype0), 64'h84);
    pe_pulse(); chk("if_avi", 64'(ptype0), 64'h82);
    pe_pulse(); chk("if_spd", 64'(ptype0), 64'h83);
    pe_pulse(); chk("if_null", 64'(ptype0), 64'h00);

    // ACR before a full ASP; dut1 gets one 8-channel frame alongside
    for (int c = 0; c < 8; c++) word1[c*20 +: 20] = {4'(c + 1), 16'hC0DE};
    valid1 = 1'b1;
    push0({16'hB001, 16'hA001});
    valid1 = 1'b0;
    push0({16'hB002, 16'hA002});
    push0({16'hB003, 16'hA003});
    push0({16'hB004, 16'hA004});
    chk("acr_level_before", 64'(level0), 64'd4);
    chk("l1_level_before", 64'(level1), 64'd1);
    acr = 1'b1; pe = 1'b1; cyc(); acr = 1'b0; pe = 1'b0;
    chk("acr_first", 64'(ptype0), 64'h01);
    chk("acr_level_held", 64'(level0), 64'd4);
    chk("acr_first_l1", 64'(ptype1), 64'h01);
    pe_pulse();
    chk("asp_type", 64'(ptype0), 64'h02);
    chk("asp_present", 64'(present0), 64'hF);
    chk("asp_level", 64'(level0), 64'd0);
    chk("asp_sp0_l0", 64'(asp0[0].lane[0]), 64'hA00100);
    chk("asp_sp3_l1", 64'(asp0[3].lane[1]), 64'hB00400);
    chk("asp_sp1_l2", 64'(asp0[1].lane[2]), 64'd0);
    chk("l1_type", 64'(ptype1), 64'h02);
    chk("l1_present", 64'(present1), 64'hF);
    chk("l1_level", 64'(level1), 64'd0);
    chk("l1_sp0_l0", 64'(asp1[0].lane[0]), 64'h1C0DE0);
    chk("l1_sp2_l1", 64'(asp1[2].lane[1]), 64'h6C0DE0);
    chk("l1_sp3_l0", 64'(asp1[3].lane[0]), 64'h7C0DE0);
    chk("l1_sp3_l7", 64'(asp1[3].lane[7]), 64'd0);
    pe_pulse();
    chk("after_asp_null", 64'(ptype0), 64'h00);
    chk("after_asp_present", 64'(present0), 64'd0);

    // Partial group released after MAX_HOLD slots
    push0({16'h5678, 16'h1234});
    pe_pulse(); chk("hold_null1", 64'(ptype0), 64'h00);
    pe_pulse(); chk("hold_null2", 64'(ptype0), 64'h00);
    pe_pulse();
    chk("hold_asp", 64'(ptype0), 64'h02);
    chk("hold_present", 64'(present0), 64'h1);
    chk("hold_l0", 64'(asp0[0].lane[0]), 64'h123400);
    chk("hold_l1", 64'(asp0[0].lane[1]), 64'h567800);
    chk("hold_sp1_zero", 64'(asp0[1].lane[0]), 64'd0);
    chk("hold_level", 64'(level0), 64'd0);

    // Full FIFO back-pressure, then pop, then simultaneous push and pop
    for (int k = 1; k <= 8; k++) push0({16'(16'hD000 + k), 16'(16'hC000 + k)});
    chk("full_level", 64'(level0), 64'd8);
    chk("full_ready", 64'(ready0), 64'd0);
    valid0 = 1'b1; word0 = 32'hEEEE_EEEE; cyc(); valid0 = 1'b0;
    chk("full_no_accept", 64'(level0), 64'd8);
    pe_pulse();
    chk("full_pop_type", 64'(ptype0), 64'h02);
    chk("full_pop_level", 64'(level0), 64'd4);
    chk("full_pop_ready", 64'(ready0), 64'd1);
    chk("full_pop_sp0", 64'(asp0[0].lane[0]), 64'hC00100);
    valid0 = 1'b1; word0 = {16'hF00F, 16'hF00F}; pe = 1'b1; cyc(); valid0 = 1'b0; pe = 1'b0;
    chk("net_level", 64'(level0), 64'd1);
    chk("net_sp0", 64'(asp0[0].lane[0]), 64'hC00500);
    chk("net_sp3", 64'(asp0[3].lane[1]), 64'hD00800);

    // Frame counter wraps modulo 192
    chk("fc_start", 64'(fc0), 64'd0);
    for (int i = 0; i < 49; i++) begin
      for (int j = 0; j < 4; j++) push0(32'((i << 16) | j));
      pe_pulse();
      chk("fc_loop_type", 64'(ptype0), 64'h02);
      ppc = 5'd31; cyc(); ppc = 5'd0;
      chk("frame_counter", 64'(fc0), 64'(((i + 1) * 4) % 192));
    end
    pe_pulse();
    chk("fc_null_type", 64'(ptype0), 64'h00);
    ppc = 5'd31; cyc(); ppc = 5'd0;
    chk("fc_no_advance", 64'(fc0), 64'd4);

    // Field end coinciding with a slot, then priority ASP over AVI
    vfe = 1'b1; pe = 1'b1; cyc(); vfe = 1'b0; pe = 1'b0;
    chk("field_aif", 64'(ptype0), 64'h84);
    pe_pulse(); chk("field_asp", 64'(ptype0), 64'h02); chk("field_asp_present", 64'(present0), 64'h1);
    pe_pulse(); chk("field_avi", 64'(ptype0), 64'h82);
    pe_pulse(); chk("field_spd", 64'(ptype0), 64'h83);
    pe_pulse(); chk("field_null", 64'(ptype0), 64'h00);

    // New ACR request on the slot serving an older one stays pending
    acr = 1'b1; cyc(); acr = 1'b0;
    acr = 1'b1; pe = 1'b1; cyc(); acr = 1'b0; pe = 1'b0;
    chk("acr_coinc1", 64'(ptype0), 64'h01);
    pe_pulse(); chk("acr_coinc2", 64'(ptype0), 64'h01);
    pe_pulse(); chk("acr_cleared", 64'(ptype0), 64'h00);

    // Asynchronous reset in the middle of an ASP
    for (int k = 0; k < 4; k++) push0({16'h4444, 16'(16'h3333 + k)});
    pe_pulse();
    chk("pre_rst_type", 64'(ptype0), 64'h02);
    chk("pre_rst_sp0", 64'(asp0[0].lane[0]), 64'h333300);
    chk("pre_rst_fc", 64'(fc0), 64'd4);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_type", 64'(ptype0), 64'h00);
    chk("arst_present", 64'(present0), 64'd0);
    chk("arst_sp0", 64'(asp0[0].lane[0]), 64'd0);
    chk("arst_level", 64'(level0), 64'd0);
    chk("arst_fc", 64'(fc0), 64'd0);
    chk("arst_ready", 64'(ready0), 64'd0);
    cyc();
    reset_n = 1'b1;
    cyc();
    pe_pulse();
    chk("post_rst_aif", 64'(ptype0), 64'h84);
    chk("post_rst_aif_l1", 64'(ptype1), 64'h84);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
